// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
//
// A division is accepted on a clock edge where the block is idle and start=1.
// The result appears WIDTH edges later, with a one-cycle done pulse. A zero
// divisor finishes on the accepting edge and sets div_by_zero.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (priority over everything)
//   start        division request, sampled only while busy=0
//   dividend     unsigned dividend, captured on an accepted start
//   divisor      unsigned divisor, captured on an accepted start
//   busy         high while an iteration sequence is running
//   done         one-cycle pulse, results valid
//   quotient     unsigned quotient (held until next completion or reset)
//   remainder    unsigned remainder (held until next completion or reset)
//   div_by_zero  set with done when the captured divisor was zero
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic StIdle = 1'b0;
  localparam logic StRun  = 1'b1;

  // Counter holds values WIDTH..0.
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic            state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder, always < divisor
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;   // captured divisor

  logic             done_d;
  logic [WIDTH-1:0] quotient_d;
  logic [WIDTH-1:0] remainder_d;
  logic             div_by_zero_d;

  // One restoring step. The shifted remainder keeps the full partial
  // remainder plus one extra bit: the remainder may use its MSB when the
  // divisor is large, so dropping it would corrupt the result.
  logic [WIDTH:0]   r_shift;
  logic             trial_ge;
  logic [WIDTH-1:0] trial_diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  always_comb begin
    r_shift    = {rem_q, quo_q[WIDTH-1]};
    trial_ge   = (r_shift >= {1'b0, dvs_q});
    // When the trial succeeds the true difference is < divisor, so the
    // WIDTH-bit modular difference is exact.
    trial_diff = r_shift[WIDTH-1:0] - dvs_q;
    rem_next   = trial_ge ? trial_diff : r_shift[WIDTH-1:0];
    quo_next   = {quo_q[WIDTH-2:0], trial_ge};
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    done_d        = 1'b0;
    quotient_d    = quotient;
    remainder_d   = remainder;
    div_by_zero_d = div_by_zero;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rem_d = '0;
          quo_d = dividend;
          dvs_d = divisor;
          cnt_d = CntW'(WIDTH);
          if (divisor == '0) begin
            // Finish immediately; busy never rises.
            quotient_d    = '1;
            remainder_d   = dividend;
            div_by_zero_d = 1'b1;
            done_d        = 1'b1;
          end else begin
            state_d       = StRun;
            div_by_zero_d = 1'b0;
          end
        end
      end

      StRun: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          // Last step: publish results and return to idle in the same edge,
          // so a start in the done cycle is accepted.
          state_d       = StIdle;
          quotient_d    = quo_next;
          remainder_d   = rem_next;
          div_by_zero_d = 1'b0;
          done_d        = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      done        <= done_d;
      quotient    <= quotient_d;
      remainder   <= remainder_d;
      div_by_zero <= div_by_zero_d;
    end
  end

  // State register drives busy directly, so busy is registered too.
  assign busy = (state_q == StRun);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider at WIDTH=4 and WIDTH=8.
module tb_seq_restoring_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=4 instance
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, z4;
  logic [3:0] q4, r4;

  // WIDTH=8 instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, z8;
  logic [7:0] q8, r8;

  seq_restoring_divider #(.WIDTH(4)) u_div4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
    .dividend    (a4),
    .divisor     (b4),
    .busy        (busy4),
    .done        (done4),
    .quotient    (q4),
    .remainder   (r4),
    .div_by_zero (z4)
  );

  seq_restoring_divider #(.WIDTH(8)) u_div8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .dividend    (a8),
    .divisor     (b8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (q8),
    .remainder   (r8),
    .div_by_zero (z8)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural models: results come from / and %, timing from a cycle countdown.
  int         m4_cnt = 0;
  logic       m4_busy = 0, m4_done = 0, m4_z = 0;
  logic [3:0] m4_q = 0, m4_r = 0, m4_pq = 0, m4_pr = 0, m4_a = 0, m4_b = 0;

  always @(posedge clk) begin
    if (rst) begin
      m4_busy <= 0; m4_done <= 0; m4_z <= 0; m4_q <= 0; m4_r <= 0; m4_cnt <= 0;
    end else begin
      m4_done <= 0;
      if (!m4_busy) begin
        if (start4) begin
          m4_a <= a4;
          m4_b <= b4;
          if (b4 == 0) begin
            m4_q <= 4'hF; m4_r <= a4; m4_z <= 1; m4_done <= 1;
          end else begin
            m4_busy <= 1; m4_cnt <= 4; m4_pq <= a4 / b4; m4_pr <= a4 % b4; m4_z <= 0;
          end
        end
      end else begin
        m4_cnt <= m4_cnt - 1;
        if (m4_cnt == 1) begin
          m4_busy <= 0; m4_q <= m4_pq; m4_r <= m4_pr; m4_done <= 1;
        end
      end
    end
  end

  int         m8_cnt = 0;
  logic       m8_busy = 0, m8_done = 0, m8_z = 0;
  logic [7:0] m8_q = 0, m8_r = 0, m8_pq = 0, m8_pr = 0, m8_a = 0, m8_b = 0;

  always @(posedge clk) begin
    if (rst) begin
      m8_busy <= 0; m8_done <= 0; m8_z <= 0; m8_q <= 0; m8_r <= 0; m8_cnt <= 0;
    end else begin
      m8_done <= 0;
      if (!m8_busy) begin
        if (start8) begin
          m8_a <= a8;
          m8_b <= b8;
          if (b8 == 0) begin
            m8_q <= 8'hFF; m8_r <= a8; m8_z <= 1; m8_done <= 1;
          end else begin
            m8_busy <= 1; m8_cnt <= 8; m8_pq <= a8 / b8; m8_pr <= a8 % b8; m8_z <= 0;
          end
        end
      end else begin
        m8_cnt <= m8_cnt - 1;
        if (m8_cnt == 1) begin
          m8_busy <= 0; m8_q <= m8_pq; m8_r <= m8_pr; m8_done <= 1;
        end
      end
    end
  end

  // Per-cycle comparison, 1 time unit after each rising edge.
  always @(posedge clk) begin
    logic [15:0] recon;
    #1;
    chk("busy4", 16'(busy4), 16'(m4_busy));
    chk("done4", 16'(done4), 16'(m4_done));
    chk("quot4", 16'(q4), 16'(m4_q));
    chk("rem4", 16'(r4), 16'(m4_r));
    chk("dbz4", 16'(z4), 16'(m4_z));
    if (m4_done && !m4_z) begin
      recon = 16'(q4) * 16'(m4_b) + 16'(r4);
      chk("inv4", recon, 16'(m4_a));
      chk("rlt4", 16'(r4 < m4_b), 16'd1);
    end
    chk("busy8", 16'(busy8), 16'(m8_busy));
    chk("done8", 16'(done8), 16'(m8_done));
    chk("quot8", 16'(q8), 16'(m8_q));
    chk("rem8", 16'(r8), 16'(m8_r));
    chk("dbz8", 16'(z8), 16'(m8_z));
    if (m8_done && !m8_z) begin
      recon = 16'(q8) * 16'(m8_b) + 16'(r8);
      chk("inv8", recon, 16'(m8_a));
      chk("rlt8", 16'(r8 < m8_b), 16'd1);
    end
  end

  // Waits (bounded) at falling edges until done is seen.
  task automatic wait_done4(input string name);
    bit seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done4) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk({name, "_timeout"}, 16'd0, 16'd1);
  endtask

  task automatic wait_done8(input string name);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk({name, "_timeout"}, 16'd0, 16'd1);
  endtask

  task automatic div4(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] eq, input logic [3:0] er, input logic ez,
                      input string name);
    @(negedge clk);
    start4 = 1; a4 = a; b4 = b;
    @(negedge clk);
    start4 = 0;
    wait_done4(name);
    chk({name, "_q"}, 16'(q4), 16'(eq));
    chk({name, "_r"}, 16'(r4), 16'(er));
    chk({name, "_z"}, 16'(z4), 16'(ez));
  endtask

  task automatic div8(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start8 = 1; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 0;
    wait_done8("rand8");
    chk("rand8_q", 16'(q8), (b == 0) ? 16'hFF : 16'(a / b));
    chk("rand8_r", 16'(r8), (b == 0) ? 16'(a) : 16'(a % b));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_busy", 16'(busy4), 16'd0);
    chk("reset_q", 16'(q4), 16'd0);
    chk("reset_z", 16'(z4), 16'd0);

    // Directed cases with hand-computed results.
    div4(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, "d13_3");
    div4(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, "d15_1");
    div4(4'd3, 4'd7, 4'd0, 4'd3, 1'b0, "d3_7");
    div4(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, "d15_15");
    div4(4'd9, 4'd0, 4'hF, 4'd9, 1'b1, "d9_0");
    div4(4'd8, 4'd2, 4'd4, 4'd0, 1'b0, "d8_2");

    // Start during busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    start4 = 1; a4 = 4'd14; b4 = 4'd4;
    @(negedge clk);
    start4 = 1; a4 = 4'd1; b4 = 4'd1;
    @(negedge clk);
    start4 = 0; a4 = 4'd7; b4 = 4'd9;
    wait_done4("ign");
    chk("ign_q", 16'(q4), 16'd3);
    chk("ign_r", 16'(r4), 16'd2);
    start4 = 1; a4 = 4'd10; b4 = 4'd3;
    @(negedge clk);
    start4 = 0;
    chk("b2b_busy", 16'(busy4), 16'd1);
    wait_done4("b2b");
    chk("b2b_q", 16'(q4), 16'd3);
    chk("b2b_r", 16'(r4), 16'd1);

    // Reset in the second busy cycle aborts with no done.
    @(negedge clk);
    start4 = 1; a4 = 4'd12; b4 = 4'd5;
    @(negedge clk);
    start4 = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstmid_busy", 16'(busy4), 16'd0);
    chk("rstmid_done", 16'(done4), 16'd0);
    chk("rstmid_q", 16'(q4), 16'd0);
    chk("rstmid_r", 16'(r4), 16'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstmid_nodone", 16'(done4), 16'd0);
    end
    div4(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, "d7_2");

    // Exhaustive WIDTH=4 sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        div4(4'(a), 4'(b), (b == 0) ? 4'hF : 4'(a / b), (b == 0) ? 4'(a) : 4'(a % b),
             (b == 0), "sweep");
      end
    end

    // Random WIDTH=8 run, with occasional zero divisors.
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      div8(ra, rb);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
